// File: rtl/multi_sync_ctl_pkg.sv
// multi_sync_ctl_pkg
//   Shared types and helpers for the multi-channel capture/sync controller.
//   - state_e     : controller state encoding
//   - timer_width : width of the shared cycle timer, sized so the largest
//                   terminal count fits with one bit of headroom
package multi_sync_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RDY  = 3'd2,
    RST_PULSE = 3'd3,
    SETTLE    = 3'd4
  } state_e;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_cycle_timer.sv
// sync_cycle_timer
//   Clearable up-counter with terminal-count compare. The count stops at the
//   terminal value instead of wrapping, so a state that lingers past its
//   terminal count keeps seeing tc_o asserted.
// Ports:
//   clk50   in   clock
//   rst     in   synchronous active-high reset (count -> 0)
//   clr_i   in   clear count to 0 on the next edge (wins over counting)
//   load_i  in   terminal-count value to compare against
//   tc_o    out  count == load_i
module sync_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk50,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] load_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == load_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_sync_ctl.sv
// multi_sync_ctl
//   Capture/sync handshake controller for N_CH sync receivers. A capture
//   trigger raises per-channel sync triggers, waits for all enabled receivers
//   to drop and then re-assert ready, then issues a mem_reset pulse and a
//   settle delay before re-arming. Handshake waits are bounded by a timeout
//   that records the offending channels in sticky error flags.
// Ports:
//   clk50        in   system clock
//   rst          in   synchronous active-high reset
//   cap_trig     in   capture request, only looked at in IDLE
//   ch_en        in   channel enable, latched on accepted trigger and on reset
//   syncr_rdy    in   per-channel receiver ready
//   err_clr      in   clears timeout_err / err_ch (a coincident timeout wins)
//   capr_rdy     out  armed, ready for cap_trig
//   sync_trig    out  per-channel sync trigger
//   mem_reset    out  sample-memory reset pulse
//   busy         out  controller not in IDLE
//   timeout_err  out  sticky timeout flag
//   err_ch       out  sticky mask of channels that caused a timeout
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | armed, capr_rdy high, waiting for cap_trig
// TRIG      | sync_trig driven, waiting for enabled receivers to drop ready
// WAIT_RDY  | waiting for enabled receivers to re-assert ready
// RST_PULSE | mem_reset high for RST_CYC cycles
// SETTLE    | mem_reset low for SETTLE_CYC cycles before re-arming
module multi_sync_ctl
  import multi_sync_ctl_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int RST_CYC    = 3,
  parameter int SETTLE_CYC = 16,
  parameter int TMO_CYC    = 1024
) (
  input  logic            clk50,
  input  logic            rst,
  input  logic            cap_trig,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] syncr_rdy,
  input  logic            err_clr,
  output logic            capr_rdy,
  output logic [N_CH-1:0] sync_trig,
  output logic            mem_reset,
  output logic            busy,
  output logic            timeout_err,
  output logic [N_CH-1:0] err_ch
);

  localparam int TW = timer_width(RST_CYC, SETTLE_CYC, TMO_CYC);
  localparam logic [TW-1:0] TMO_TC    = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] RST_TC    = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYC - 1);

  state_e state_q, state_d;

  logic [N_CH-1:0] en_mask_q, en_mask_d;
  logic [N_CH-1:0] sync_trig_q, sync_trig_d;
  logic [N_CH-1:0] err_ch_q, err_ch_d;
  logic            capr_rdy_q, capr_rdy_d;
  logic            mem_reset_q, mem_reset_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;

  logic [N_CH-1:0] rdy_masked;
  logic            all_rdy, all_drop;
  logic [TW-1:0]   tmr_load;
  logic            tmr_clr, tmr_tc;

  // Disabled channels never block either handshake phase; with an empty
  // mask both conditions hold and the cycle runs straight through.
  assign rdy_masked = syncr_rdy & en_mask_q;
  assign all_rdy    = (rdy_masked == en_mask_q);
  assign all_drop   = (rdy_masked == '0);

  sync_cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk50  (clk50),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    en_mask_d     = en_mask_q;
    tmr_load      = '0;
    // Clear first, then OR in any new timeout so a coincident set wins.
    err_ch_d      = err_clr ? '0   : err_ch_q;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

    case (state_q)
      IDLE: begin
        if (cap_trig) begin
          en_mask_d = ch_en;
          state_d   = TRIG;
        end
      end
      TRIG: begin
        tmr_load = TMO_TC;
        if (all_drop) begin
          state_d = WAIT_RDY;
        end else if (tmr_tc) begin
          err_ch_d      = err_ch_d | rdy_masked;
          timeout_err_d = 1'b1;
          state_d       = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        tmr_load = TMO_TC;
        if (all_rdy) begin
          state_d = RST_PULSE;
        end else if (tmr_tc) begin
          // Degraded run: flag the stragglers but still reset the memories.
          err_ch_d      = err_ch_d | (~syncr_rdy & en_mask_q);
          timeout_err_d = 1'b1;
          state_d       = RST_PULSE;
        end
      end
      RST_PULSE: begin
        tmr_load = RST_TC;
        if (tmr_tc) state_d = SETTLE;
      end
      SETTLE: begin
        tmr_load = SETTLE_TC;
        if (tmr_tc) state_d = IDLE;
      end
      default: begin
        state_d = WAIT_RDY;
      end
    endcase

    tmr_clr = (state_d != state_q);

    // Outputs are decoded from the next state so they are registered yet
    // line up exactly with the state they belong to.
    sync_trig_d = (state_d == TRIG) ? en_mask_d : '0;
    capr_rdy_d  = (state_d == IDLE);
    mem_reset_d = (state_d == RST_PULSE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q       <= WAIT_RDY;
      en_mask_q     <= ch_en;
      sync_trig_q   <= '0;
      capr_rdy_q    <= 1'b0;
      mem_reset_q   <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
      err_ch_q      <= '0;
    end else begin
      state_q       <= state_d;
      en_mask_q     <= en_mask_d;
      sync_trig_q   <= sync_trig_d;
      capr_rdy_q    <= capr_rdy_d;
      mem_reset_q   <= mem_reset_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      err_ch_q      <= err_ch_d;
    end
  end

  assign capr_rdy    = capr_rdy_q;
  assign sync_trig   = sync_trig_q;
  assign mem_reset   = mem_reset_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign err_ch      = err_ch_q;

endmodule

// File: doc/multi_sync_ctl.md
Name: multi_sync_ctl

Overview:
Capture/sync handshake controller for N sync receivers, successor to the single-channel capture-sync controller. On a capture trigger it raises per-channel sync triggers, waits for every enabled receiver to drop and then re-assert ready, and issues a mem_reset pulse followed by a settle delay before re-arming. It adds a per-channel enable mask, programmable pulse and settle lengths, handshake timeouts with sticky error reporting, and a busy flag. It sits between the capture front end and the sample memories in the clk50 domain.

Parameters:
N_CH, 2, number of sync receiver channels (1..16)
RST_CYC, 3, mem_reset pulse length in clk50 cycles (>=1)
SETTLE_CYC, 16, cycles mem_reset stays low before capr_rdy rises (>=1)
TMO_CYC, 1024, handshake timeout in cycles per wait state (>=2)

Ports:
clk50  in  1  system clock, 50 MHz
rst  in  1  reset, synchronous, active-high
cap_trig  in  1  capture request; sampled only in IDLE
ch_en  in  N_CH  channel enable; latched into en_mask on accepted cap_trig and on leaving reset
syncr_rdy  in  N_CH  per-channel receiver ready
err_clr  in  1  clears timeout_err and err_ch
capr_rdy  out  1  controller armed, ready for cap_trig
sync_trig  out  N_CH  per-channel sync trigger (en_mask while in TRIG)
mem_reset  out  1  memory reset pulse
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky timeout flag
err_ch  out  N_CH  sticky OR of channels that caused a timeout

Behaviour:
- Reset values: capr_rdy=0, sync_trig=0, mem_reset=0, busy=1, timeout_err=0, err_ch=0; state=WAIT_RDY; timer=0; en_mask<=ch_en.
- All outputs are registered. "All ready" means (syncr_rdy & en_mask)==en_mask. "All dropped" means (syncr_rdy & en_mask)==0. Both are true when en_mask==0.
- IDLE: capr_rdy=1. If cap_trig is sampled high at edge k, then at k+1: en_mask<=ch_en, sync_trig<=ch_en, capr_rdy<=0, state TRIG, timer cleared.
- TRIG: if all dropped, then next cycle sync_trig<=0 and state WAIT_RDY. Timeout (timer==TMO_CYC-1): err_ch|=syncr_rdy&en_mask, timeout_err<=1, sync_trig<=0, state WAIT_RDY.
- WAIT_RDY: if all ready, go to RST_PULSE. Timeout: err_ch|=~syncr_rdy&en_mask, timeout_err<=1, and proceed to RST_PULSE anyway (degraded run; no deadlock).
- RST_PULSE: mem_reset=1 for exactly RST_CYC consecutive cycles, then SETTLE.
- SETTLE: mem_reset=0 for exactly SETTLE_CYC cycles. capr_rdy rises on the following edge; state IDLE.
- A single shared timer counts up and clears on every state change. Its width is clog2(max(RST_CYC, SETTLE_CYC, TMO_CYC))+1, and it never wraps.
- cap_trig outside IDLE is ignored (not queued). ch_en changes outside latch points have no effect.
- err_clr clears err_ch and timeout_err. If err_clr coincides with a new timeout, the timeout wins (set has priority).
- rst mid-operation: all outputs return to reset values on the next edge, including an immediate drop of any sync_trig or mem_reset in progress.

Decomposition:
- Package multi_sync_ctl_pkg: state enum (IDLE, TRIG, WAIT_RDY, RST_PULSE, SETTLE) and a clog2-based timer-width function.
- One sub-module, sync_cycle_timer: clearable up-counter with terminal-count compare (load value, clear, tc out), instantiated once.

Test Plan:
- Config N_CH=2, RST_CYC=3, SETTLE_CYC=16, TMO_CYC=64. Hold both rdy high from reset -> mem_reset high exactly 3 cycles, then 16 low cycles, then capr_rdy=1, busy=0.
- ch_en=2'b11, pulse cap_trig -> sync_trig=2'b11 next cycle. Drop rdy[0] at t, rdy[1] at t+5 -> sync_trig clears one cycle after t+5. Re-raise both -> mem_reset 3 cycles, capr_rdy after 16 more; no error.
- ch_en=2'b01, rdy[1] stuck low -> sync_trig=2'b01; ch1 ignored; completes with timeout_err=0.
- rdy[1] never drops in TRIG -> after 64 cycles timeout_err=1, err_ch=2'b10, sync_trig=0. Flow then continues to mem_reset. err_clr -> both flags cleared.
- Pulse cap_trig repeatedly during SETTLE -> no reaction. After capr_rdy=1, a single trigger is accepted.
- Assert rst during RST_PULSE cycle 2 -> mem_reset=0 next edge; state WAIT_RDY; capr_rdy=0; normal re-arm follows.
